// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: default widths, FSM encoding
// and small state-classification helpers.
package program_loader_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_CHECK   = 3'd2,
    ST_RELEASE = 3'd3,
    ST_DONE    = 3'd4,
    ST_ERROR   = 3'd5
  } state_t;

  // States in which a start pulse is honoured.
  function automatic logic can_start(input state_t s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERROR);
  endfunction

  // States that report busy to the host.
  function automatic logic is_busy(input state_t s);
    return (s == ST_LOAD) || (s == ST_CHECK) || (s == ST_RELEASE);
  endfunction

  // States in which the byte stream is accepted.
  function automatic logic takes_bytes(input state_t s);
    return (s == ST_LOAD) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/program_loader_load_addr_counter.sv
// Write-address counter for the loader. Latches the byte count on clear and
// flags the final address of the load. A length of 0 means the full address
// space, which falls out naturally from len-1 wrapping to all ones.
module load_addr_counter #(
  parameter int ADDR_W = 12
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              inc_i,
  input  logic [ADDR_W-1:0] len_i,
  output logic [ADDR_W-1:0] count_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] count_q, count_d;
  logic [ADDR_W-1:0] len_q, len_d;

  // Clear wins over increment; the length is captured only on clear.
  always_comb begin
    count_d = count_q;
    len_d   = len_q;
    if (clr_i) begin
      count_d = '0;
      len_d   = len_i;
    end else if (inc_i) begin
      count_d = count_q + ADDR_W'(1);
    end
  end

  // Counter and length registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      len_q   <= '0;
    end else begin
      count_q <= count_d;
      len_q   <= len_d;
    end
  end

  // Current address is the last one of this load.
  assign count_o = count_q;
  assign last_o  = (count_q == (len_q - ADDR_W'(1)));

endmodule

// File: rtl/program_loader.sv
// Program loader: fills the uP program memory from a valid/ready byte stream,
// verifies a trailing 8-bit checksum and only then releases the uP from reset.
// Every output is a register; next values are derived from the next state so
// status flags change together with the state.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock_i,
  input  logic              reset_ni,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] load_len_i,
  input  logic [DATA_W-1:0] in_byte_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic              rom_we_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  output logic [DATA_W-1:0] rom_wdata_o,
  output logic              cpu_reset_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  state_t            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              rom_we_q, rom_we_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [DATA_W-1:0] rom_wdata_q, rom_wdata_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic [DATA_W-1:0] sum_chk;

  logic              xfer;
  logic              load_xfer;
  logic              chk_xfer;
  logic              start_ok;
  logic              cnt_clr;
  logic              cnt_inc;
  logic [ADDR_W-1:0] count;
  logic              last;

  // Handshake uses the registered ready, so the source sees a stable signal.
  assign xfer      = in_valid_i & in_ready_q;
  assign load_xfer = xfer & (state_q == ST_LOAD);
  assign chk_xfer  = xfer & (state_q == ST_CHECK);
  assign start_ok  = start_i & can_start(state_q);
  // Abort masks every side effect of the same cycle.
  assign cnt_clr   = start_ok & ~abort_i;
  assign cnt_inc   = load_xfer & ~abort_i;
  assign sum_chk   = sum_q + in_byte_i;

  load_addr_counter #(
    .ADDR_W (ADDR_W)
  ) u_cnt (
    .clk_i   (clock_i),
    .rst_ni  (reset_ni),
    .clr_i   (cnt_clr),
    .inc_i   (cnt_inc),
    .len_i   (load_len_i),
    .count_o (count),
    .last_o  (last)
  );

  // State register.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic; abort overrides start and any transfer.
  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: if (start_i) state_d = ST_LOAD;
        ST_LOAD:    if (load_xfer && last) state_d = ST_CHECK;
        ST_CHECK:   if (chk_xfer) state_d = (sum_chk == '0) ? ST_RELEASE : ST_ERROR;
        ST_RELEASE: state_d = ST_DONE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Output and datapath next values, keyed off the next state.
  always_comb begin
    in_ready_d  = takes_bytes(state_d);
    busy_d      = is_busy(state_d);
    done_d      = (state_d == ST_DONE);
    err_d       = (state_d == ST_ERROR);
    cpu_reset_d = (state_d != ST_DONE);
    rom_we_d    = cnt_inc;
    rom_addr_d  = rom_addr_q;
    rom_wdata_d = rom_wdata_q;
    sum_d       = sum_q;
    if (cnt_inc) begin
      rom_addr_d  = count;
      rom_wdata_d = in_byte_i;
      sum_d       = sum_chk;
    end else if (cnt_clr) begin
      sum_d       = '0;
    end
  end

  // Output and checksum registers.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      in_ready_q  <= 1'b0;
      rom_we_q    <= 1'b0;
      rom_addr_q  <= '0;
      rom_wdata_q <= '0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      sum_q       <= '0;
    end else begin
      in_ready_q  <= in_ready_d;
      rom_we_q    <= rom_we_d;
      rom_addr_q  <= rom_addr_d;
      rom_wdata_q <= rom_wdata_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      sum_q       <= sum_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign rom_we_o    = rom_we_q;
  assign rom_addr_o  = rom_addr_q;
  assign rom_wdata_o = rom_wdata_q;
  assign cpu_reset_o = cpu_reset_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule
